// File: rtl/can_pkg.sv
// Shared types and sizes for the CAN transmit scheduler.
package can_pkg;

    localparam int FRAME_W  = 108;
    localparam int ID_W     = 11;
    localparam int NUM_MBOX = 4;
    localparam int SEL_W    = $clog2(NUM_MBOX);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        BUSY,
        IFS
    } sched_state_t;

    typedef logic [SEL_W-1:0] mbox_idx_t;

    function automatic logic [ID_W-1:0] mbox_id(
        input logic [NUM_MBOX*ID_W-1:0] ids,
        input mbox_idx_t                m
    );
        return ids[m*ID_W +: ID_W];
    endfunction

endpackage

// File: rtl/can_prio_select.sv
// Combinational priority pick: pending mailbox with the smallest identifier,
// ties going to the lowest mailbox index.
module can_prio_select
    import can_pkg::*;
(
    input  logic [NUM_MBOX-1:0]      pend,
    input  logic [NUM_MBOX*ID_W-1:0] ids,
    output mbox_idx_t                win,
    output logic                     valid
);

    logic [ID_W-1:0] best_id;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        win     = '0;
        valid   = 1'b0;
        best_id = '1;
        // Strict less-than keeps the earlier (lower-index) mailbox on equal IDs.
        for (int m = 0; m < NUM_MBOX; m++) begin
            if (pend[m] && (!valid || mbox_id(ids, mbox_idx_t'(m)) < best_id)) begin
                win     = mbox_idx_t'(m);
                valid   = 1'b1;
                best_id = mbox_id(ids, mbox_idx_t'(m));
            end
        end
    end

endmodule

// File: rtl/can_tx_sched.sv
// Transmit scheduler: waits for an idle bus, loads the highest-priority pending
// mailbox into can_tx, reports done/lost per mailbox and enforces intermission.
module can_tx_sched
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int IDLE_BITS    = 11,
    parameter int IFS_BITS     = 3
) (
    input  logic                         i_Clock,
    input  logic                         i_Rst_n,
    input  logic [NUM_MBOX-1:0]          i_Req,
    input  logic [NUM_MBOX-1:0]          i_Abort,
    input  logic [NUM_MBOX*ID_W-1:0]     i_Id,
    input  logic [NUM_MBOX*FRAME_W-1:0]  i_Frame,
    input  logic                         i_Rx_Serial,
    input  logic                         i_Tx_Done,
    input  logic                         i_Arb_Lost,
    output logic                         o_Tx_DV,
    output logic [FRAME_W-1:0]           o_Tx_Frame,
    output logic [NUM_MBOX-1:0]          o_Pending,
    output logic [NUM_MBOX-1:0]          o_Done,
    output logic [NUM_MBOX-1:0]          o_Lost,
    output logic                         o_Bus_Idle
);

    localparam int IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int IFS_CYC  = IFS_BITS * CLKS_PER_BIT;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
    localparam int IFS_W    = $clog2(IFS_CYC + 1);

    sched_state_t        state, state_next;
    logic [NUM_MBOX-1:0] pend, pend_next, inflight;
    mbox_idx_t           sel, win;
    logic                win_valid;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IFS_W-1:0]    ifs_cnt;
    logic                bus_idle;
    logic                tx_dv_d;
    logic [NUM_MBOX-1:0] done_d, lost_d;

    can_prio_select u_prio (
        .pend  (pend),
        .ids   (i_Id),
        .win   (win),
        .valid (win_valid)
    );

    assign bus_idle = (idle_cnt == IDLE_W'(IDLE_MAX));

    // State register
    always_ff @(posedge i_Clock) begin
        // NOTE: nonblocking assignments so every flop updates from pre-edge values.
        if (!i_Rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (|pend && bus_idle) state_next = SELECT;
            SELECT:  state_next = win_valid ? START : IDLE;
            START:   state_next = BUSY;
            BUSY:    if (i_Arb_Lost || i_Tx_Done) state_next = IFS;
            IFS:     if (ifs_cnt == IFS_W'(IFS_CYC - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic, registered below so no input reaches an output combinationally
    always_comb begin
        tx_dv_d = 1'b0;
        done_d  = '0;
        lost_d  = '0;
        case (state)
            SELECT: tx_dv_d = win_valid;
            BUSY: begin
                if (i_Arb_Lost)     lost_d[sel] = 1'b1;
                else if (i_Tx_Done) done_d[sel] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        inflight = '0;
        if (state == START || state == BUSY) inflight[sel] = 1'b1;
    end

    // Abort beats a same-cycle request; completion retires the in-flight mailbox.
    assign pend_next = ((pend | i_Req) & ~(i_Abort & ~inflight)) & ~done_d;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            pend       <= '0;
            sel        <= '0;
            idle_cnt   <= '0;
            ifs_cnt    <= '0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Frame <= '0;
            o_Done     <= '0;
            o_Lost     <= '0;
        end else begin
            pend    <= pend_next;
            o_Tx_DV <= tx_dv_d;
            o_Done  <= done_d;
            o_Lost  <= lost_d;

            if (state == SELECT) sel <= win;
            if (tx_dv_d)         o_Tx_Frame <= i_Frame[win*FRAME_W +: FRAME_W];

            if (!i_Rx_Serial)  idle_cnt <= '0;
            else if (!bus_idle) idle_cnt <= idle_cnt + 1'b1;

            if (state == IFS) ifs_cnt <= ifs_cnt + 1'b1;
            else              ifs_cnt <= '0;
        end
    end

    assign o_Pending  = pend;
    assign o_Bus_Idle = bus_idle;

endmodule

// File: tb/tb_can_tx_sched.sv
// Directed bench for can_tx_sched: expected frames are queued when requests are
// made and compared as each load strobe appears.
module tb_can_tx_sched;
    import can_pkg::*;

    localparam int IFS_CYC = 30;

    logic                        i_Clock = 1'b0;
    logic                        i_Rst_n;
    logic [NUM_MBOX-1:0]         i_Req, i_Abort;
    logic [NUM_MBOX*ID_W-1:0]    i_Id;
    logic [NUM_MBOX*FRAME_W-1:0] i_Frame;
    logic                        i_Rx_Serial, i_Tx_Done, i_Arb_Lost;
    logic                        o_Tx_DV, o_Bus_Idle;
    logic [FRAME_W-1:0]          o_Tx_Frame;
    logic [NUM_MBOX-1:0]         o_Pending, o_Done, o_Lost;

    can_tx_sched dut (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Req       (i_Req),
        .i_Abort     (i_Abort),
        .i_Id        (i_Id),
        .i_Frame     (i_Frame),
        .i_Rx_Serial (i_Rx_Serial),
        .i_Tx_Done   (i_Tx_Done),
        .i_Arb_Lost  (i_Arb_Lost),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Frame  (o_Tx_Frame),
        .o_Pending   (o_Pending),
        .o_Done      (o_Done),
        .o_Lost      (o_Lost),
        .o_Bus_Idle  (o_Bus_Idle)
    );

    always #5 i_Clock = ~i_Clock;

    int checks = 0;
    int errors = 0;
    int dv_count = 0;
    logic [FRAME_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FRAME_W-1:0] mk_frame(input int m);
        return {27{4'(10 + m)}};
    endfunction

    // Scoreboard consumer: each load strobe must match the oldest expected frame
    always @(negedge i_Clock) begin
        if (o_Tx_DV === 1'b1) begin
            dv_count++;
            if (exp_q.size() == 0) check("unexpected_tx_dv", o_Tx_DV, 1'b0);
            else                   check("tx_frame", o_Tx_Frame, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge i_Clock);
        #1;
    endtask

    // kind 0: o_Tx_DV, 1: any o_Done, 2: any o_Lost
    task automatic wait_for(input int kind, input int budget, input string tag, output int cyc);
        bit found;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < budget) begin
            tick();
            cyc++;
            case (kind)
                0:       found = (o_Tx_DV === 1'b1);
                1:       found = (o_Done != '0);
                default: found = (o_Lost != '0);
            endcase
        end
        check({tag, "_seen"}, 128'(found), 128'(1));
    endtask

    task automatic set_ids(input logic [10:0] a, b, c, d);
        i_Id = {d, c, b, a};
    endtask

    task automatic pulse_done();
        i_Tx_Done = 1'b1;
        tick();
        i_Tx_Done = 1'b0;
    endtask

    task automatic quiet_window(input int n, input string tag);
        int snap;
        snap = dv_count;
        repeat (n) tick();
        check(tag, 128'(dv_count), 128'(snap));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int order[4];

        i_Rst_n = 1'b0; i_Req = '0; i_Abort = '0; i_Rx_Serial = 1'b1;
        i_Tx_Done = 1'b0; i_Arb_Lost = 1'b0;
        i_Frame = {mk_frame(3), mk_frame(2), mk_frame(1), mk_frame(0)};
        set_ids(11'h123, 11'h200, 11'h300, 11'h400);

        // Reset state
        repeat (3) tick();
        check("rst_pending", o_Pending, 4'b0000);
        check("rst_tx_dv",   o_Tx_DV, 1'b0);
        check("rst_frame",   o_Tx_Frame, '0);
        check("rst_done",    o_Done, 4'b0000);
        check("rst_lost",    o_Lost, 4'b0000);
        check("rst_idle",    o_Bus_Idle, 1'b0);

        // Bus-idle boundary: asserted on exactly the 110th recessive sample
        i_Rst_n = 1'b1;
        repeat (109) tick();
        check("idle_at_109", o_Bus_Idle, 1'b0);
        tick();
        check("idle_at_110", o_Bus_Idle, 1'b1);

        // Single request
        exp_q.push_back(mk_frame(0));
        i_Req = 4'b0001;
        tick();
        i_Req = '0;
        check("single_pending", o_Pending, 4'b0001);
        wait_for(0, 20, "single_dv", cyc);
        check("single_latency", 128'(cyc + 1), 128'(3));
        tick();
        pulse_done();
        check("single_done", o_Done, 4'b0001);
        check("single_pend_clr", o_Pending, 4'b0000);

        // Priority with equal IDs on mailboxes 1 and 2
        set_ids(11'h400, 11'h0FF, 11'h0FF, 11'h7FF);
        order = '{1, 2, 0, 3};
        foreach (order[i]) exp_q.push_back(mk_frame(order[i]));
        repeat (40) tick();
        i_Req = 4'b1111;
        tick();
        i_Req = '0;
        check("prio_pending", o_Pending, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                wait_for(0, 20, "prio_first_dv", cyc);
            end else begin
                wait_for(0, 100, "prio_dv", cyc);
                check("prio_ifs_spacing", 128'(cyc), 128'(IFS_CYC + 2));
            end
            tick();
            pulse_done();
            check("prio_done", o_Done, 128'(4'b0001 << order[i]));
        end
        check("prio_all_clear", o_Pending, 4'b0000);

        // Arbitration lost, then lost+done together, then success
        repeat (3) exp_q.push_back(mk_frame(2));
        repeat (40) tick();
        i_Req = 4'b0100;
        tick();
        i_Req = '0;
        wait_for(0, 20, "arb_dv", cyc);
        tick();
        i_Arb_Lost = 1'b1;
        tick();
        i_Arb_Lost = 1'b0;
        check("arb_lost", o_Lost, 4'b0100);
        check("arb_no_done", o_Done, 4'b0000);
        check("arb_pend_kept", o_Pending, 4'b0100);
        wait_for(0, 100, "arb_retry_dv", cyc);
        check("arb_retry_spacing", 128'(cyc), 128'(IFS_CYC + 2));
        tick();
        i_Arb_Lost = 1'b1;
        i_Tx_Done = 1'b1;
        tick();
        i_Arb_Lost = 1'b0;
        i_Tx_Done = 1'b0;
        check("both_lost", o_Lost, 4'b0100);
        check("both_no_done", o_Done, 4'b0000);
        check("both_pend_kept", o_Pending, 4'b0100);
        wait_for(0, 100, "arb_retry2_dv", cyc);
        tick();
        pulse_done();
        check("arb_final_done", o_Done, 4'b0100);
        check("arb_final_clear", o_Pending, 4'b0000);

        // Abort: queued mailbox 3 cleared, in-flight mailbox 0 unaffected
        exp_q.push_back(mk_frame(0));
        repeat (40) tick();
        i_Req = 4'b1001;
        tick();
        i_Req = '0;
        wait_for(0, 20, "abort_dv", cyc);
        tick();
        i_Abort = 4'b1001;
        tick();
        i_Abort = '0;
        check("abort_pending", o_Pending, 4'b0001);
        pulse_done();
        check("abort_inflight_done", o_Done, 4'b0001);
        check("abort_clear", o_Pending, 4'b0000);
        i_Req = 4'b0100;
        i_Abort = 4'b0100;
        tick();
        i_Req = '0;
        i_Abort = '0;
        check("req_abort_same", o_Pending, 4'b0000);
        quiet_window(150, "abort_no_dv");

        // Bus busy: a dominant bit every 50 clocks keeps the bus from going idle
        exp_q.push_back(mk_frame(1));
        i_Rx_Serial = 1'b0;
        i_Req = 4'b0010;
        tick();
        i_Req = '0;
        begin
            int snap;
            snap = dv_count;
            for (int j = 1; j < 200; j++) begin
                i_Rx_Serial = (j % 50 == 0) ? 1'b0 : 1'b1;
                tick();
            end
            check("busy_no_dv", 128'(dv_count), 128'(snap));
        end
        check("busy_pending", o_Pending, 4'b0010);
        check("busy_not_idle", o_Bus_Idle, 1'b0);
        i_Rx_Serial = 1'b0;
        tick();
        i_Rx_Serial = 1'b1;
        wait_for(0, 200, "busy_dv", cyc);
        check("busy_dv_delay", 128'(cyc), 128'(112));
        tick();
        pulse_done();
        check("busy_done", o_Done, 4'b0010);

        // Reset while BUSY
        exp_q.push_back(mk_frame(1));
        repeat (40) tick();
        i_Req = 4'b0010;
        tick();
        i_Req = '0;
        wait_for(0, 20, "rstb_dv", cyc);
        tick();
        i_Rst_n = 1'b0;
        tick();
        i_Rst_n = 1'b1;
        check("rstb_state", dut.state, IDLE);
        check("rstb_pending", o_Pending, 4'b0000);
        check("rstb_tx_dv", o_Tx_DV, 1'b0);
        check("rstb_frame", o_Tx_Frame, '0);
        check("rstb_done", o_Done, 4'b0000);
        check("rstb_lost", o_Lost, 4'b0000);
        check("rstb_idle", o_Bus_Idle, 1'b0);
        tick();
        pulse_done();
        check("rstb_no_stray_done", o_Done, 4'b0000);
        quiet_window(150, "rstb_no_dv");
        check("rstb_idle_again", o_Bus_Idle, 1'b1);

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_tx_sched.md
# can_tx_sched

Transmit scheduler for the CAN controller: holds up to four pending transmit mailboxes and picks the pending mailbox with the lowest (highest-priority) 11-bit identifier. It waits for the bus to be idle, then loads the chosen 108-bit frame into `can_tx`. It reports completion or lost arbitration per mailbox and enforces interframe spacing between attempts. It sits between the host-side mailbox registers and `can_tx`, and observes the bus through the same serial line that feeds `can_rx`.

## Interface
- `CLKS_PER_BIT`, 10: clocks per CAN bit; must match `can_tx`/`can_rx`.
- `IDLE_BITS`, 11: consecutive recessive bits required before the bus counts as idle.
- `IFS_BITS`, 3: intermission bit times after every attempt, whether it succeeded or lost arbitration.
- `i_Clock` in 1: sole clock; all logic on its rising edge.
- `i_Rst_n` in 1: synchronous, active-low reset.
- `i_Req` in 4: per-mailbox transmit request pulse.
- `i_Abort` in 4: per-mailbox cancel pulse.
- `i_Id` in 44: mailbox m identifier at bits [11m+10:11m].
- `i_Frame` in 432: mailbox m frame at bits [108m+107:108m], in `can_tx` bit order.
- `i_Rx_Serial` in 1: bus level; 1 means recessive.
- `i_Tx_Done` in 1: 1-cycle pulse from `can_tx` when a frame completes.
- `i_Arb_Lost` in 1: 1-cycle pulse from `can_tx` when it loses bitwise arbitration.
- `o_Tx_DV` out 1: 1-cycle load strobe to `can_tx`.
- `o_Tx_Frame` out 108: frame presented with `o_Tx_DV`; held until the next load.
- `o_Pending` out 4: registered pending flags.
- `o_Done` out 4: 1-cycle per-mailbox success pulse.
- `o_Lost` out 4: 1-cycle per-mailbox arbitration-lost pulse.
- `o_Bus_Idle` out 1: bus-idle flag.

## Operation
- **Reset values:** all outputs 0; state IDLE; `pend`=0; counters=0; `sel`=0.
- **Pending register:**
  - `i_Req[m]` sets `pend[m]`. A request on an already-pending mailbox is a no-op.
  - `i_Abort[m]` clears `pend[m]` unless m is in flight (states START/BUSY with `sel`=m); aborting the in-flight mailbox is ignored.
  - Req and Abort on the same mailbox in the same cycle: Abort wins.
  - Requesters hold `i_Id`/`i_Frame` stable while their mailbox is pending.
- **Idle counter:**
  - Counts clocks while `i_Rx_Serial`=1 and clears to 0 on any 0.
  - Saturates at `IDLE_BITS*CLKS_PER_BIT`.
  - `o_Bus_Idle`=1 while saturated.
- **FSM:**
  - IDLE: if `pend`≠0 and `o_Bus_Idle`, go to SELECT.
  - SELECT: latch `sel` = pending mailbox with the smallest `i_Id`; equal IDs resolve to the lowest index. Go to START. If `pend` became 0 this cycle, return to IDLE.
  - START: `o_Tx_DV`=1 and `o_Tx_Frame`=frame[`sel`] for one cycle. Go to BUSY.
  - BUSY, on `i_Arb_Lost`: pulse `o_Lost[sel]`; `pend[sel]` stays set; go to IFS. If `i_Arb_Lost` and `i_Tx_Done` arrive together, `i_Arb_Lost` wins.
  - BUSY, on `i_Tx_Done`: pulse `o_Done[sel]`; clear `pend[sel]`; go to IFS.
  - IFS: count `IFS_BITS*CLKS_PER_BIT` cycles, then go to IDLE.
- The pending set is re-evaluated every time the FSM enters SELECT. A higher-priority request that arrives during BUSY or IFS therefore wins the next attempt.
- **Reset mid-frame:** the scheduler returns to IDLE, and all pending requests and pulses are dropped. `can_tx` is reset by the same `i_Rst_n`.

## Timing
- `i_Req` sampled at edge k with the bus idle and the FSM in IDLE:
  - `o_Pending` high after k.
  - SELECT after k+1.
  - `o_Tx_DV` high for the cycle after k+2.
- `o_Done`/`o_Lost` are high in the cycle after the edge that samples `i_Tx_Done`/`i_Arb_Lost`.
- Minimum spacing between consecutive `o_Tx_DV` pulses: `IFS_BITS*CLKS_PER_BIT`+2 cycles after the completion pulse, provided the bus is already idle.
- Frame transmission itself drives the bus dominant, so the idle counter restarts naturally after each frame.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `can_pkg`:
  - `FRAME_W`=108, `ID_W`=11, `NUM_MBOX`=4.
  - State enumeration IDLE/SELECT/START/BUSY/IFS.
- Sub-module `can_prio_select`: combinational selector that takes the 4 pending flags and the 4 IDs and returns the winning index and a valid flag. It is kept separate so the priority rule can be verified exhaustively in isolation.

## Test plan
- **Single request:** bus held 1 for >110 clocks, then `i_Req`=0001 with ID 0x123. Expect `o_Tx_DV` 3 cycles later with frame 0; after `i_Tx_Done`, `o_Done`=0001 and `o_Pending`=0000.
- **Priority:** requests on mailboxes 0..3 with IDs 0x400, 0x0FF, 0x0FF, 0x7FF, all completing. Expect transmit order 1, 2, 0, 3, with ≥30 cycles of IFS between `o_Done` and the next `o_Tx_DV`.
- **Arbitration lost:** `i_Arb_Lost` pulsed during BUSY. Expect `o_Lost` for that mailbox, pending stays 1, and a retry after IFS plus bus idle. Pulsing `i_Arb_Lost` and `i_Tx_Done` in the same cycle gives `o_Lost` only.
- **Bus busy:** `i_Rx_Serial` toggled to 0 every 50 clocks with a request pending. Expect no `o_Tx_DV` until 110 consecutive recessive clocks.
- **Abort:**
  - Aborting a queued mailbox clears it, with no `o_Tx_DV` for it.
  - Aborting the in-flight mailbox is ignored and it still completes with `o_Done`.
  - Same-cycle Req and Abort leaves the mailbox not pending.
- **Reset mid-BUSY:** `i_Rst_n`=0 for 1 cycle. Expect all outputs 0, state IDLE, `o_Pending`=0000, and no stray `o_Done` when `i_Tx_Done` arrives later.
